// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of all request/response and RAM-side signals of the
// two-master RAM arbiter.
//   slave  : arbiter view. It takes the master requests and RAM read data, and
//            drives ready/rdata, the registered RAM strobes, and busy.
//   master : environment view. This covers both requesting masters and the RAM model.
// Signals:
//   m{0,1}_valid/addr/wdata/wmask : request from each master (wmask 0 = read)
//   m{0,1}_ready/rdata            : completion pulse and held read data
//   mem_addr/access/wmask/wdata   : registered RAM controls
//   mem_rdata                     : RAM read data, one cycle after mem_access
//   busy                          : arbiter not idle
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m0_valid, m1_valid;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [3:0]        m0_wmask, m1_wmask;
    logic              m0_ready, m1_ready;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_access;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    modport slave (
        input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wmask, m1_wmask, mem_rdata,
        output m0_ready, m1_ready, m0_rdata, m1_rdata,
               mem_addr, mem_access, mem_wmask, mem_wdata, busy
    );

    modport master (
        output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wmask, m1_wmask, mem_rdata,
        input  m0_ready, m1_ready, m0_rdata, m1_rdata,
               mem_addr, mem_access, mem_wmask, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-port synchronous RAM
// between two valid/ready masters. Each granted access takes the path
// IDLE -> ISSUE -> WAIT -> RESP. The flow is grant, then strobe, then RAM
// latency, then a ready pulse. Every output is a register.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (master requests, RAM controls, busy)
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              gnt;        // granted master index
    logic              last_grant; // master served most recently
    logic [3:0]        req_wmask;  // latched wmask; mem_wmask clears after ISSUE

    logic              want;
    logic              pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wmask;

    // Arbitration. When both masters request, the one not served last wins.
    always_comb begin
        want = bus.m0_valid | bus.m1_valid;
        pick = 1'b0;
        if (bus.m0_valid && bus.m1_valid)
            pick = ~last_grant;
        else
            pick = bus.m1_valid;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
        sel_wmask = pick ? bus.m1_wmask : bus.m0_wmask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            last_grant     <= 1'b1;
            req_wmask      <= 4'b0;
            bus.m0_ready   <= 1'b0;
            bus.m1_ready   <= 1'b0;
            bus.m0_rdata   <= 32'b0;
            bus.m1_rdata   <= 32'b0;
            bus.mem_addr   <= '0;
            bus.mem_access <= 1'b0;
            bus.mem_wmask  <= 4'b0;
            bus.mem_wdata  <= 32'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.m0_ready <= 1'b0;
            bus.m1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (want) begin
                        // mem_addr and mem_wdata hold the latched request
                        // until the next grant.
                        gnt            <= pick;
                        req_wmask      <= sel_wmask;
                        bus.mem_addr   <= sel_addr;
                        bus.mem_wdata  <= sel_wdata;
                        bus.mem_access <= (sel_wmask == 4'b0);
                        bus.mem_wmask  <= sel_wmask;
                        bus.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    // RAM samples at this edge; strobes last one cycle only
                    bus.mem_access <= 1'b0;
                    bus.mem_wmask  <= 4'b0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (req_wmask == 4'b0) begin
                        if (gnt) bus.m1_rdata <= bus.mem_rdata;
                        else     bus.m0_rdata <= bus.mem_rdata;
                    end
                    if (gnt) bus.m1_ready <= 1'b1;
                    else     bus.m0_ready <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    last_grant <= gnt;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small synchronous
// RAM model (64 words, one-cycle read latency, byte writes).
// Inputs are driven and outputs sampled on the falling clock edge.
// "Cycle 0" is the cycle in which a request is first presented.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(32)) bus();
    mem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] ram [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_data;
        if (bus.mem_access) bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) ram[bus.mem_addr[7:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wmask = '0;
        bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wmask = '0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", bus.busy); end
        checks++; if (bus.m0_ready !== 1'b0 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b%0b exp 00", bus.m0_ready, bus.m1_ready); end
        checks++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h exp 0 0", bus.m0_rdata, bus.m1_rdata); end
        checks++; if (bus.mem_access !== 1'b0 || bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_strobes: got %0b %h exp 0 0", bus.mem_access, bus.mem_wmask); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_regs: got %h %h exp 0 0", bus.mem_addr, bus.mem_wdata); end
        preload(6'd4,  32'hDEADBEEF);
        preload(6'd8,  32'h11223344);
        preload(6'd12, 32'hA0A0A0A0);
        preload(6'd13, 32'hB1B1B1B1);
        preload(6'd16, 32'h00000000);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h10; bus.m0_wmask = 4'h0;
        tick(); // cycle 1
        checks++; if (bus.mem_access !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL rd_issue: got access=%0b addr=%h exp 1 10", bus.mem_access, bus.mem_addr); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %0b exp 1", bus.busy); end
        tick(); // cycle 2
        checks++; if (bus.mem_access !== 1'b0 || bus.m0_ready !== 1'b0) begin errors++; $display("FAIL rd_wait: got access=%0b ready=%0b exp 0 0", bus.mem_access, bus.m0_ready); end
        tick(); // cycle 3
        checks++; if (bus.m0_ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ready: got %0b exp 1", bus.m0_ready); end
        checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m0_rdata: got %h exp deadbeef", bus.m0_rdata); end
        checks++; if (bus.m1_ready !== 1'b0) begin errors++; $display("FAIL rd_m1_ready: got %0b exp 0", bus.m1_ready); end
        bus.m0_valid = 1'b0;
        tick(); // cycle 4
        checks++; if (bus.busy !== 1'b0 || bus.m0_ready !== 1'b0) begin errors++; $display("FAIL rd_done: got busy=%0b ready=%0b exp 0 0", bus.busy, bus.m0_ready); end
        checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h exp deadbeef", bus.m0_rdata); end
    endtask

    task automatic test_byte_write();
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h000000AB; bus.m1_wmask = 4'b0001;
        tick(); // cycle 1
        checks++; if (bus.mem_wmask !== 4'b0001 || bus.mem_access !== 1'b0) begin errors++; $display("FAIL wr_issue: got wmask=%b access=%0b exp 0001 0", bus.mem_wmask, bus.mem_access); end
        checks++; if (bus.mem_wdata !== 32'h000000AB || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL wr_data: got %h @%h exp 000000ab @20", bus.mem_wdata, bus.mem_addr); end
        tick(); // cycle 2
        checks++; if (bus.mem_wmask !== 4'b0000) begin errors++; $display("FAIL wr_one_cycle: got %b exp 0000", bus.mem_wmask); end
        tick(); // cycle 3
        checks++; if (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got m1=%0b m0=%0b exp 1 0", bus.m1_ready, bus.m0_ready); end
        bus.m1_valid = 1'b0;
        tick();
        checks++; if (ram[8] !== 32'h112233AB) begin errors++; $display("FAIL wr_ram: got %h exp 112233ab", ram[8]); end
        bus.m1_valid = 1'b1; bus.m1_wmask = 4'b0000;
        repeat (3) tick();
        checks++; if (bus.m1_ready !== 1'b1 || bus.m1_rdata !== 32'h112233AB) begin errors++; $display("FAIL wr_readback: got ready=%0b %h exp 1 112233ab", bus.m1_ready, bus.m1_rdata); end
        checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_no_crosstalk: got %h exp deadbeef", bus.m0_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_valid_dropped();
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h10; bus.m0_wmask = 4'h0;
        tick(); // cycle 1
        bus.m0_valid = 1'b0;
        repeat (2) tick(); // cycle 3
        checks++; if (bus.m0_ready !== 1'b1 || bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL drop_ready: got %0b %h exp 1 deadbeef", bus.m0_ready, bus.m0_rdata); end
        for (int c = 4; c <= 5; c++) begin
            tick();
            checks++; if (bus.busy !== 1'b0 || bus.mem_access !== 1'b0) begin errors++; $display("FAIL drop_idle_c%0d: got busy=%0b access=%0b exp 0 0", c, bus.busy, bus.mem_access); end
        end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h30; bus.m0_wmask = 4'h0;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h34; bus.m1_wmask = 4'h0;
        for (int c = 1; c <= 16; c++) begin
            logic e0, e1, eb;
            tick();
            e0 = (c == 3) || (c == 11);
            e1 = (c == 7) || (c == 15);
            eb = (c % 4) != 0;
            checks++; if (bus.m0_ready !== e0 || bus.m1_ready !== e1) begin errors++; $display("FAIL tie_ready_c%0d: got m0=%0b m1=%0b exp %0b %0b", c, bus.m0_ready, bus.m1_ready, e0, e1); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL tie_busy_c%0d: got %0b exp %0b", c, bus.busy, eb); end
            if (c == 7 || c == 15) begin
                checks++; if (bus.m0_rdata !== 32'hA0A0A0A0 || bus.m1_rdata !== 32'hB1B1B1B1) begin errors++; $display("FAIL tie_rdata_c%0d: got %h %h exp a0a0a0a0 b1b1b1b1", c, bus.m0_rdata, bus.m1_rdata); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h20; bus.m1_wmask = 4'h0;
        repeat (2) tick(); // cycle 2 (WAIT)
        reset = 1'b1;
        tick(); // cycle 3
        checks++; if (bus.busy !== 1'b0 || bus.m0_ready !== 1'b0 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy=%0b ready=%0b%0b exp 0 00", bus.busy, bus.m0_ready, bus.m1_ready); end
        checks++; if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h %h exp 0 0", bus.m0_rdata, bus.m1_rdata); end
        reset = 1'b0;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h10; bus.m0_wmask = 4'h0;
        tick(); // new cycle 1
        checks++; if (bus.mem_access !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL rmid_tie_grant: got access=%0b addr=%h exp 1 10", bus.mem_access, bus.mem_addr); end
        repeat (2) tick();
        checks++; if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0 || bus.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_tie_resp: got m0=%0b m1=%0b %h exp 1 0 deadbeef", bus.m0_ready, bus.m1_ready, bus.m0_rdata); end
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_reset_write_issue();
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h40; bus.m0_wdata = 32'hCAFEF00D; bus.m0_wmask = 4'hF;
        tick(); // cycle 1 (ISSUE)
        checks++; if (bus.mem_wmask !== 4'hF) begin errors++; $display("FAIL rwr_issue: got %h exp f", bus.mem_wmask); end
        reset = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL rwr_after: got busy=%0b wmask=%h exp 0 0", bus.busy, bus.mem_wmask); end
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.m0_ready !== 1'b0 || bus.m1_ready !== 1'b0) begin errors++; $display("FAIL rwr_no_ready_%0d: got %0b%0b exp 00", c, bus.m0_ready, bus.m1_ready); end
            tick();
        end
        checks++; if (ram[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL rwr_ram: got %h exp cafef00d", ram[16]); end
    endtask

    initial begin
        idle_inputs();
        bus.mem_rdata = 32'h0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_valid_dropped();
        test_simultaneous();
        test_reset_mid();
        test_reset_write_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
